// File: rtl/addr_map_cfg_pkg.sv
// Shared types for the address-map programmer: rule layout, field selector and FSM states.
// ADDR_MAP_CFG_OVERLAP_CHK_EN adds the pairwise overlap state.
package addr_map_cfg_pkg;

  localparam int unsigned RuleWidth = 160;

  typedef struct packed {
    logic [31:0] idx;
    logic [63:0] start_addr;
    logic [63:0] end_addr;
  } rule_t;

  typedef enum logic [1:0] {
    FieldIdx   = 2'd0,
    FieldStart = 2'd1,
    FieldEnd   = 2'd2,
    FieldRsvd  = 2'd3
  } field_e;

  typedef enum logic [2:0] {
    StIdle,
    StCheck,
`ifdef ADDR_MAP_CFG_OVERLAP_CHK_EN
    StPair,
`endif
    StCommit,
    StErr
  } state_e;

  // Ones in the low `width` bits; addresses are held zero-extended to 64 bits.
  function automatic logic [63:0] addr_mask(int unsigned width);
    return {64{1'b1}} >> (64 - width);
  endfunction

endpackage

// File: rtl/addr_map_cfg_if.sv
// Configuration/commit bus of addr_map_cfg; names carry the direction seen from the programmer.
interface addr_map_cfg_if #(
  parameter int unsigned NoRules = 4
);
  localparam int unsigned RuleIdxW = (NoRules > 1) ? $clog2(NoRules) : 1;

  logic                      cfg_we_i;
  logic [RuleIdxW-1:0]       cfg_rule_i;
  logic [1:0]                cfg_field_i;
  logic [63:0]               cfg_wdata_i;
  logic                      cfg_drop_o;
  logic                      commit_req_i;
  logic                      commit_busy_o;
  logic                      commit_done_o;
  logic                      commit_err_o;
  logic [RuleIdxW-1:0]       err_rule_o;
  logic                      map_valid_o;
  logic [NoRules*160-1:0]    addr_map_o;

  modport master (
    output cfg_we_i, cfg_rule_i, cfg_field_i, cfg_wdata_i, commit_req_i,
    input  cfg_drop_o, commit_busy_o, commit_done_o, commit_err_o, err_rule_o, map_valid_o,
           addr_map_o
  );

  modport slave (
    input  cfg_we_i, cfg_rule_i, cfg_field_i, cfg_wdata_i, commit_req_i,
    output cfg_drop_o, commit_busy_o, commit_done_o, commit_err_o, err_rule_o, map_valid_o,
           addr_map_o
  );
endinterface

// File: rtl/addr_rule_check.sv
// Combinational legality check of a single rule (index range and range/NAPOT shape).
module addr_rule_check
  import addr_map_cfg_pkg::*;
#(
  parameter int unsigned NoIndices = 4,
  parameter int unsigned AddrWidth = 64,
  parameter int unsigned Napot     = 0
) (
  input  rule_t rule_i,
  output logic  ok_o
);

  localparam logic [63:0] AddrMask = addr_mask(AddrWidth);

  logic        idx_ok;
  logic        shape_ok;
  logic [63:0] mask;

  always_comb begin
    idx_ok = rule_i.idx < NoIndices;
    mask   = ~rule_i.end_addr & AddrMask;
    if (Napot != 0) begin
      // Inverted mask must be a run of low ones, and start must be aligned to it.
      shape_ok = ((mask & (mask + 64'd1) & AddrMask) == '0) &&
                 ((rule_i.start_addr & ~rule_i.end_addr & AddrMask) == '0);
    end else begin
      shape_ok = (rule_i.end_addr == '0) || (rule_i.start_addr < rule_i.end_addr);
    end
    ok_o = idx_ok && shape_ok;
  end

endmodule

// File: rtl/addr_map_cfg.sv
// Shadow/active rule table programmer: field writes, serial validation, atomic swap.
// ADDR_MAP_CFG_OVERLAP_CHK_EN enables the serial pairwise overlap check before commit.
module addr_map_cfg
  import addr_map_cfg_pkg::*;
#(
  parameter int unsigned NoRules   = 4,
  parameter int unsigned NoIndices = 4,
  parameter int unsigned AddrWidth = 64,
  parameter int unsigned Napot     = 0
) (
  input logic           clk_i,
  input logic           rst_i,
  addr_map_cfg_if.slave bus
);

  localparam int unsigned         RuleIdxW = (NoRules > 1) ? $clog2(NoRules) : 1;
  localparam logic [RuleIdxW-1:0] LastRule = RuleIdxW'(NoRules - 1);
  localparam logic [63:0]         AddrMask = addr_mask(AddrWidth);

  state_e                 state_q, state_d;
  logic [RuleIdxW-1:0]    r_q, r_d;
  rule_t [NoRules-1:0]    shadow_q, shadow_d;
  rule_t [NoRules-1:0]    active_q, active_d;
  logic                   valid_q, valid_d;
  logic                   drop_q, drop_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;
  logic [RuleIdxW-1:0]    err_rule_q, err_rule_d;
  logic                   rule_ok;
  logic                   wr_ok;

  addr_rule_check #(
    .NoIndices (NoIndices),
    .AddrWidth (AddrWidth),
    .Napot     (Napot)
  ) u_rule_check (
    .rule_i (shadow_q[r_q]),
    .ok_o   (rule_ok)
  );

`ifdef ADDR_MAP_CFG_OVERLAP_CHK_EN
  // r_q doubles as the lower rule `a` of the pair; b_q is the upper rule.
  logic [RuleIdxW-1:0] b_q, b_d;
  logic                overlap;
  rule_t               rule_a, rule_b;
  logic [64:0]         end_a, end_b;

  always_comb begin
    rule_a = shadow_q[r_q];
    rule_b = shadow_q[b_q];
    end_a  = (rule_a.end_addr == '0) ? (65'd1 << AddrWidth) : {1'b0, rule_a.end_addr};
    end_b  = (rule_b.end_addr == '0) ? (65'd1 << AddrWidth) : {1'b0, rule_b.end_addr};
    if (Napot != 0) begin
      overlap = ((rule_a.start_addr ^ rule_b.start_addr) & rule_a.end_addr & rule_b.end_addr
                 & AddrMask) == '0;
    end else begin
      overlap = ({1'b0, rule_a.start_addr} < end_b) && ({1'b0, rule_b.start_addr} < end_a);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) b_q <= '0;
    else       b_q <= b_d;
  end
`endif

  assign wr_ok = (state_q == StIdle) && (field_e'(bus.cfg_field_i) != FieldRsvd) &&
                 (32'(bus.cfg_rule_i) < NoRules);

  always_comb begin
    state_d    = state_q;
    r_d        = r_q;
    shadow_d   = shadow_q;
    active_d   = active_q;
    valid_d    = valid_q;
    drop_d     = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;
    err_rule_d = err_rule_q;
`ifdef ADDR_MAP_CFG_OVERLAP_CHK_EN
    b_d        = b_q;
`endif

    if (bus.cfg_we_i) begin
      if (wr_ok) begin
        unique case (field_e'(bus.cfg_field_i))
          FieldIdx:   shadow_d[bus.cfg_rule_i].idx        = bus.cfg_wdata_i[31:0];
          FieldStart: shadow_d[bus.cfg_rule_i].start_addr = bus.cfg_wdata_i & AddrMask;
          FieldEnd:   shadow_d[bus.cfg_rule_i].end_addr   = bus.cfg_wdata_i & AddrMask;
          default:    ;
        endcase
      end else begin
        drop_d = 1'b1;
      end
    end

    unique case (state_q)
      StIdle: begin
        if (bus.commit_req_i) begin
          state_d = StCheck;
          r_d     = '0;
        end
      end
      StCheck: begin
        if (!rule_ok) begin
          state_d = StErr;
        end else if (r_q == LastRule) begin
`ifdef ADDR_MAP_CFG_OVERLAP_CHK_EN
          if (NoRules > 1) begin
            state_d = StPair;
            r_d     = '0;
            b_d     = RuleIdxW'(1);
          end else begin
            state_d = StCommit;
          end
`else
          state_d = StCommit;
`endif
        end else begin
          r_d = r_q + 1'b1;
        end
      end
`ifdef ADDR_MAP_CFG_OVERLAP_CHK_EN
      StPair: begin
        if (overlap) begin
          state_d = StErr;
        end else if (b_q == LastRule) begin
          if (r_q == LastRule - 1'b1) begin
            state_d = StCommit;
          end else begin
            r_d = r_q + 1'b1;
            b_d = r_q + RuleIdxW'(2);
          end
        end else begin
          b_d = b_q + 1'b1;
        end
      end
`endif
      StCommit: begin
        active_d = shadow_q;
        valid_d  = 1'b1;
        done_d   = 1'b1;
        state_d  = StIdle;
      end
      StErr: begin
        err_d      = 1'b1;
        err_rule_d = r_q;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      r_q        <= '0;
      shadow_q   <= '0;
      active_q   <= '0;
      valid_q    <= 1'b0;
      drop_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_rule_q <= '0;
    end else begin
      state_q    <= state_d;
      r_q        <= r_d;
      shadow_q   <= shadow_d;
      active_q   <= active_d;
      valid_q    <= valid_d;
      drop_q     <= drop_d;
      done_q     <= done_d;
      err_q      <= err_d;
      err_rule_q <= err_rule_d;
    end
  end

  assign bus.cfg_drop_o    = drop_q;
  assign bus.commit_busy_o = (state_q != StIdle);
  assign bus.commit_done_o = done_q;
  assign bus.commit_err_o  = err_q;
  assign bus.err_rule_o    = err_rule_q;
  assign bus.map_valid_o   = valid_q;
  assign bus.addr_map_o    = active_q;

endmodule

// File: tb/tb_addr_map_cfg.sv
// Directed + randomized bench for addr_map_cfg against a rule-level reference model.
module tb_addr_map_cfg;

  localparam int unsigned NoR  = 4;
  localparam int unsigned NoIx = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  addr_map_cfg_if #(.NoRules(NoR)) bus ();

  addr_map_cfg #(
    .NoRules   (NoR),
    .NoIndices (NoIx),
    .AddrWidth (64),
    .Napot     (0)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model: shadow and active tables as plain arrays.
  logic [31:0] m_idx[NoR];
  logic [63:0] m_st [NoR];
  logic [63:0] m_en [NoR];
  logic [31:0] a_idx[NoR];
  logic [63:0] a_st [NoR];
  logic [63:0] a_en [NoR];
  bit          m_valid;
  int          m_err_rule;

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NoR; i++) begin
      m_idx[i] = '0; m_st[i] = '0; m_en[i] = '0;
      a_idx[i] = '0; a_st[i] = '0; a_en[i] = '0;
    end
    m_valid    = 1'b0;
    m_err_rule = 0;
  endtask

  function automatic bit legal(int r);
    return (m_idx[r] < NoIx) && ((m_en[r] == 0) || (m_st[r] < m_en[r]));
  endfunction

  function automatic bit overlaps(int a, int b);
    logic [64:0] ea, eb;
    ea = (m_en[a] == 0) ? 65'h1_0000_0000_0000_0000 : {1'b0, m_en[a]};
    eb = (m_en[b] == 0) ? 65'h1_0000_0000_0000_0000 : {1'b0, m_en[b]};
    return ({1'b0, m_st[a]} < eb) && ({1'b0, m_st[b]} < ea);
  endfunction

  task automatic check_map(input string tag);
    chk({tag, ":valid"}, 160'(bus.map_valid_o), 160'(m_valid));
    for (int i = 0; i < NoR; i++)
      chk($sformatf("%s:map%0d", tag, i), bus.addr_map_o[i*160 +: 160],
          {a_idx[i], a_st[i], a_en[i]});
  endtask

  // Called #1 after a clock edge; one-cycle write strobe.
  task automatic wr(input int rule, input int field, input logic [63:0] data);
    bus.cfg_we_i    = 1'b1;
    bus.cfg_rule_i  = 2'(rule);
    bus.cfg_field_i = 2'(field);
    bus.cfg_wdata_i = data;
    @(posedge clk); #1;
    bus.cfg_we_i = 1'b0;
    chk($sformatf("drop_r%0d_f%0d", rule, field), 160'(bus.cfg_drop_o), 160'(field == 3));
    case (field)
      0: m_idx[rule] = data[31:0];
      1: m_st[rule]  = data;
      2: m_en[rule]  = data;
      default: ;
    endcase
  endtask

  task automatic set_rule(input int r, input int idx, input logic [63:0] s, input logic [63:0] e);
    wr(r, 0, 64'(idx));
    wr(r, 1, s);
    wr(r, 2, e);
  endtask

  task automatic commit(input string tag, input bit poke);
    bit exp_err = 1'b0;
    int exp_rule = 0;
    int exp_cyc;
    int cyc = 0;
    int p = 0;
    bit got_done = 1'b0;
    bit got_err = 1'b0;
    exp_cyc = NoR + 1;
    for (int r = 0; r < NoR && !exp_err; r++)
      if (!legal(r)) begin
        exp_err = 1'b1; exp_rule = r; exp_cyc = r + 2;
      end
`ifdef ADDR_MAP_CFG_OVERLAP_CHK_EN
    if (!exp_err) begin
      exp_cyc = NoR + 1 + NoR * (NoR - 1) / 2;
      for (int a = 0; a < NoR && !exp_err; a++)
        for (int b = a + 1; b < NoR && !exp_err; b++) begin
          if (overlaps(a, b)) begin
            exp_err = 1'b1; exp_rule = a; exp_cyc = NoR + 2 + p;
          end
          p++;
        end
    end
`endif
    bus.commit_req_i = 1'b1;
    @(posedge clk); #1;
    bus.commit_req_i = 1'b0;
    chk({tag, ":busy"}, 160'(bus.commit_busy_o), 160'(1));
    while (!got_done && !got_err && cyc < 100) begin
      if (poke && cyc == 1) begin
        bus.cfg_we_i    = 1'b1;
        bus.cfg_rule_i  = 2'($urandom_range(0, 3));
        bus.cfg_field_i = 2'($urandom_range(0, 2));
        bus.cfg_wdata_i = {$urandom, $urandom};
      end
      @(posedge clk); #1;
      cyc++;
      if (poke && cyc == 2) begin
        bus.cfg_we_i = 1'b0;
        chk({tag, ":drop_busy"}, 160'(bus.cfg_drop_o), 160'(1));
      end
      got_done = bus.commit_done_o;
      got_err  = bus.commit_err_o;
    end
    chk({tag, ":cycles"}, 160'(cyc), 160'(exp_cyc));
    chk({tag, ":done"}, 160'(got_done), 160'(!exp_err));
    chk({tag, ":err"}, 160'(got_err), 160'(exp_err));
    if (exp_err) begin
      m_err_rule = exp_rule;
    end else begin
      for (int i = 0; i < NoR; i++) begin
        a_idx[i] = m_idx[i]; a_st[i] = m_st[i]; a_en[i] = m_en[i];
      end
      m_valid = 1'b1;
    end
    chk({tag, ":err_rule"}, 160'(bus.err_rule_o), 160'(m_err_rule));
    chk({tag, ":idle"}, 160'(bus.commit_busy_o), 160'(0));
    check_map(tag);
    @(posedge clk); #1;
    chk({tag, ":pulse_end"}, 160'({bus.commit_done_o, bus.commit_err_o}), 160'(0));
  endtask

  initial begin
    bus.cfg_we_i     = 1'b0;
    bus.cfg_rule_i   = '0;
    bus.cfg_field_i  = '0;
    bus.cfg_wdata_i  = '0;
    bus.commit_req_i = 1'b0;
    model_reset();
    #12 rst = 1'b0;
    @(posedge clk); #1;

    // Reset state
    chk("rst:busy", 160'(bus.commit_busy_o), 160'(0));
    chk("rst:pulses", 160'({bus.cfg_drop_o, bus.commit_done_o, bus.commit_err_o}), 160'(0));
    chk("rst:err_rule", 160'(bus.err_rule_o), 160'(0));
    check_map("rst");

    // Basic table, then end==0 rule 3 (overlaps everything when overlap checking is on)
    set_rule(0, 0, 64'h0,    64'h1000);
    set_rule(1, 1, 64'h1000, 64'h2000);
    set_rule(2, 2, 64'h2000, 64'h0);
    set_rule(3, 3, 64'h0,    64'h0);
    wr(3, 3, 64'hdead);
    commit("basic", 1'b0);

    wr(2, 0, 64'd4);
    commit("bad_idx", 1'b0);
    wr(2, 0, 64'd2);

    wr(1, 1, 64'h3000);
    commit("bad_range", 1'b0);
    wr(1, 2, 64'h0);
    commit("open_end", 1'b0);

    commit("poke", 1'b1);

    set_rule(0, 0, 64'h0,    64'h2000);
    set_rule(1, 1, 64'h1000, 64'h3000);
    commit("overlap", 1'b0);

    set_rule(0, 0, 64'h0,    64'h1000);
    set_rule(1, 1, 64'h1000, 64'h2000);
    set_rule(2, 2, 64'h3000, 64'h4000);
    set_rule(3, 3, 64'h4000, 64'h5000);
    commit("disjoint", 1'b0);

    for (int it = 0; it < 40; it++) begin
      int nw = $urandom_range(1, 4);
      for (int w = 0; w < nw; w++) begin
        int r = $urandom_range(0, 3);
        int f = $urandom_range(0, 3);
        logic [63:0] d;
        if (f == 0)                          d = 64'($urandom_range(0, 4));
        else if ($urandom_range(0, 9) == 0)  d = {$urandom, $urandom};
        else if (f == 2 && $urandom_range(0, 3) == 0) d = 64'h0;
        else                                 d = 64'($urandom_range(f == 1 ? 0 : 1, 8)) << 12;
        wr(r, f, d);
      end
      commit($sformatf("rnd%0d", it), ($urandom_range(0, 3) == 0));
    end

    // Ensure a valid active map, then reset in the middle of CHECK
    set_rule(0, 0, 64'h0,    64'h1000);
    set_rule(1, 1, 64'h1000, 64'h2000);
    set_rule(2, 2, 64'h3000, 64'h4000);
    set_rule(3, 3, 64'h4000, 64'h5000);
    commit("pre_rst", 1'b0);
    bus.commit_req_i = 1'b1;
    @(posedge clk); #1;
    bus.commit_req_i = 1'b0;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    model_reset();
    chk("midrst:busy", 160'(bus.commit_busy_o), 160'(0));
    check_map("midrst");
    #3 rst = 1'b0;
    @(posedge clk); #1;
    commit("post_rst", 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
